// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath blocks.
//   - mul_state_e : state encoding of the iterative multiplier control FSM
//   - MULU / MULS : control-unit opcodes that select the multiplier
//   - is_mul_op   : decode helper used by the control unit
// -----------------------------------------------------------------------------
package alu_pkg;

    // The multiplier has only two states: waiting for a request, or stepping
    // through the shift-add iterations.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_state_e;

    // Multiply opcodes as decoded by the control unit. MULS selects the
    // two's-complement interpretation of the operands.
    localparam logic [5:0] MULU = 6'b011001;
    localparam logic [5:0] MULS = 6'b011011;

    // True for either multiply opcode; the control unit uses this to decide
    // when to raise start towards seq_mul_unit.
    function automatic logic is_mul_op(input logic [5:0] opcode);
        return (opcode == MULU) || (opcode == MULS);
    endfunction

    // True when the opcode requests a signed multiply.
    function automatic logic is_signed_mul_op(input logic [5:0] opcode);
        return opcode == MULS;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// -----------------------------------------------------------------------------
// mul_sign_fix
// Conditional two's-complement negate. Used both to take the magnitude of the
// operands before the unsigned shift-add loop and to restore the sign of the
// finished product.
// Ports:
//   value_in   in   WIDTH   value to be conditionally negated
//   negate     in   1       1: output is -value_in, 0: output is value_in
//   value_out  out  WIDTH   result (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module mul_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_in,
    input  logic             negate,
    output logic [WIDTH-1:0] value_out
);

    // Negation is invert-plus-one. The most-negative value maps onto itself,
    // which read as an unsigned number is exactly its magnitude, so the
    // multiplier needs no special case for it.
    always_comb begin
        value_out = value_in;
        if (negate) begin
            value_out = ~value_in + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_mul_unit.sv
// -----------------------------------------------------------------------------
// seq_mul_unit
// Iterative shift-add multiplier for the ALU. One partial product is added per
// clock, so a multiply occupies the unit for a fixed WIDTH+1 cycles from the
// start request to the done pulse, independent of the operand values. Signed
// multiplies are done on operand magnitudes and the sign is fixed afterwards.
// Ports:
//   clk        in   1        clock, all state changes on the rising edge
//   reset      in   1        synchronous active-high reset, aborts any operation
//   start      in   1        request, accepted only while ready is high
//   is_signed  in   1        two's-complement operands (sampled with start)
//   dataA      in   WIDTH    multiplicand (sampled with start)
//   dataB      in   WIDTH    multiplier (sampled with start)
//   ready      out  1        unit idle and able to accept start
//   busy       out  1        multiply in progress
//   done       out  1        one-cycle pulse when dataOut has been updated
//   dataOut    out  2*WIDTH  product, held until the next completion or reset
// -----------------------------------------------------------------------------
module seq_mul_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dataOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_e           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [2*WIDTH-1:0]   acc_q,      acc_d;
    logic [2*WIDTH-1:0]   mcnd_q,     mcnd_d;
    logic [WIDTH-1:0]     mpy_q,      mpy_d;
    logic                 neg_q,      neg_d;
    logic                 done_q,     done_d;
    logic [2*WIDTH-1:0]   data_out_q, data_out_d;

    logic                 signed_mode;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   product_fixed;

    // A build without signed support ignores is_signed entirely, so the sign
    // bits of the operands are then plain magnitude bits.
    always_comb begin
        signed_mode = is_signed & SIGNED_EN;
        neg_a       = signed_mode & dataA[WIDTH-1];
        neg_b       = signed_mode & dataB[WIDTH-1];
    end

    // Operand magnitudes, taken combinationally so they can be captured on
    // the accepting edge without an extra cycle.
    mul_sign_fix #(
        .WIDTH (WIDTH)
    ) u_abs_a (
        .value_in  (dataA),
        .negate    (neg_a),
        .value_out (abs_a)
    );

    mul_sign_fix #(
        .WIDTH (WIDTH)
    ) u_abs_b (
        .value_in  (dataB),
        .negate    (neg_b),
        .value_out (abs_b)
    );

    // One shift-add step: the shifted multiplicand is added whenever the
    // current lowest multiplier bit is set. The carry out of the top bit can
    // never be needed because the magnitude product fits in 2*WIDTH bits.
    always_comb begin
        acc_step = acc_q;
        if (mpy_q[0]) begin
            acc_step = acc_q + mcnd_q;
        end
    end

    // The last step's sum is sign-corrected on the way into the output
    // register, so the result appears in the same edge as the final add.
    mul_sign_fix #(
        .WIDTH (2 * WIDTH)
    ) u_fix_out (
        .value_in  (acc_step),
        .negate    (neg_q),
        .value_out (product_fixed)
    );

    // Control and datapath next-state. In IDLE a start captures the operand
    // magnitudes and the result sign; in RUN every cycle performs one step and
    // the step with the counter at WIDTH-1 publishes the product and returns
    // to IDLE, which makes ready high in the done cycle for back-to-back use.
    // A start seen while in RUN is simply not looked at.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcnd_d     = mcnd_q;
        mpy_d      = mpy_q;
        neg_d      = neg_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcnd_d  = {{WIDTH{1'b0}}, abs_a};
                    mpy_d   = abs_b;
                    neg_d   = signed_mode & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                end
            end
            ST_RUN: begin
                acc_d  = acc_step;
                mcnd_d = mcnd_q << 1;
                mpy_d  = mpy_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    data_out_d = product_fixed;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset clears everything including the visible result,
    // so an aborted multiply leaves no stale product behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcnd_q     <= '0;
            mpy_q      <= '0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcnd_q     <= mcnd_d;
            mpy_q      <= mpy_d;
            neg_q      <= neg_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
        end
    end

    // Handshake outputs are straight decodes of registered state.
    always_comb begin
        ready   = (state_q == ST_IDLE);
        busy    = (state_q == ST_RUN);
        done    = done_q;
        dataOut = data_out_q;
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_unit
// Directed-vector bench for seq_mul_unit. The driver pushes the hand-computed
// product and the cycle in which done must appear into a queue per DUT; a
// monitor per DUT pops and compares whenever done is seen.
// DUTs: 32-bit signed-capable, 32-bit unsigned-only, 8-bit signed-capable.
// -----------------------------------------------------------------------------
module tb_seq_mul_unit;

    localparam int W     = 32;
    localparam int LAT   = W + 1;
    localparam int LAT_8 = 8 + 1;

    typedef struct {
        logic [63:0] data;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cycle_cnt = 0;
    int          checks_total = 0;
    int          checks_passed = 0;

    exp_t        q_main[$];
    exp_t        q_ns[$];
    exp_t        q_w8[$];

    logic        start, is_signed;
    logic [31:0] data_a, data_b;
    logic        ready, busy, done;
    logic [63:0] data_out;

    logic        start_ns, is_signed_ns;
    logic [31:0] data_a_ns, data_b_ns;
    logic        ready_ns, busy_ns, done_ns;
    logic [63:0] data_out_ns;

    logic        start_8, is_signed_8;
    logic [7:0]  data_a_8, data_b_8;
    logic        ready_8, busy_8, done_8;
    logic [15:0] data_out_8;

    seq_mul_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dataA     (data_a),
        .dataB     (data_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .dataOut   (data_out)
    );

    seq_mul_unit #(.WIDTH(32), .SIGNED_EN(1'b0)) u_dut_ns (
        .clk       (clk),
        .reset     (reset),
        .start     (start_ns),
        .is_signed (is_signed_ns),
        .dataA     (data_a_ns),
        .dataB     (data_b_ns),
        .ready     (ready_ns),
        .busy      (busy_ns),
        .done      (done_ns),
        .dataOut   (data_out_ns)
    );

    seq_mul_unit #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut_w8 (
        .clk       (clk),
        .reset     (reset),
        .start     (start_8),
        .is_signed (is_signed_8),
        .dataA     (data_a_8),
        .dataB     (data_b_8),
        .ready     (ready_8),
        .busy      (busy_8),
        .done      (done_8),
        .dataOut   (data_out_8)
    );

    // Free-running clock and an edge counter that the latency checks use as
    // a timestamp; it is stable whenever the bench looks at it on a negedge.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
    end

    // Every comparison goes through here so the counters stay consistent.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks_total++;
        $display("[TB] FAIL %s: done seen with no operation outstanding (got 1, expected 0)", name);
    endtask

    // Issue one request to the main DUT at the current negedge, record the
    // expectation, then scramble the operand inputs after the accepting edge.
    task automatic applyStimulus(input string name, input logic sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expected);
        exp_t e;
        e.data = expected;
        e.cyc  = cycle_cnt + LAT;
        e.name = name;
        q_main.push_back(e);
        start     = 1'b1;
        is_signed = sgn;
        data_a    = a;
        data_b    = b;
        @(negedge clk);
        start     = 1'b0;
        data_a    = $urandom;
        data_b    = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Issue a request and wait until one cycle past its done cycle.
    task automatic runOp(input string name, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expected);
        applyStimulus(name, sgn, a, b, expected);
        repeat (LAT) @(negedge clk);
    endtask

    // Scoreboard monitors: each done pops one expectation and checks both the
    // product and the cycle in which it appeared.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (q_main.size() == 0) begin
                reportUnexpected("main done");
            end else begin
                e = q_main.pop_front();
                checkOutput({e.name, " data"}, data_out, e.data);
                checkOutput({e.name, " done cycle"}, 64'(cycle_cnt), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done_ns) begin
            if (q_ns.size() == 0) begin
                reportUnexpected("nosign done");
            end else begin
                e = q_ns.pop_front();
                checkOutput({e.name, " data"}, data_out_ns, e.data);
                checkOutput({e.name, " done cycle"}, 64'(cycle_cnt), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done_8) begin
            if (q_w8.size() == 0) begin
                reportUnexpected("w8 done");
            end else begin
                e = q_w8.pop_front();
                checkOutput({e.name, " data"}, {48'd0, data_out_8}, e.data);
                checkOutput({e.name, " done cycle"}, 64'(cycle_cnt), 64'(e.cyc));
            end
        end
    end

    // Directed sequence.
    initial begin
        exp_t e;
        int   waited;

        reset        = 1'b1;
        start        = 1'b0;
        is_signed    = 1'b0;
        data_a       = '0;
        data_b       = '0;
        start_ns     = 1'b0;
        is_signed_ns = 1'b0;
        data_a_ns    = '0;
        data_b_ns    = '0;
        start_8      = 1'b0;
        is_signed_8  = 1'b0;
        data_a_8     = '0;
        data_b_8     = '0;

        repeat (2) @(negedge clk);
        // Reset must win over a simultaneous start.
        start  = 1'b1;
        data_a = 32'd3;
        data_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        checkOutput("reset ready", 64'(ready), 64'd1);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset dataOut", data_out, 64'd0);
        @(negedge clk);
        checkOutput("reset-vs-start busy", 64'(busy), 64'd0);

        // Side DUTs run alongside the first main multiply.
        start_ns     = 1'b1;
        is_signed_ns = 1'b1;
        data_a_ns    = 32'hFFFF_FFFF;
        data_b_ns    = 32'd2;
        e.data = 64'h0000_0001_FFFF_FFFE;
        e.cyc  = cycle_cnt + LAT;
        e.name = "nosign FFFFFFFF*2";
        q_ns.push_back(e);
        start_8     = 1'b1;
        is_signed_8 = 1'b1;
        data_a_8    = 8'h80;
        data_b_8    = 8'h7F;
        e.data = 64'h0000_0000_0000_C080;
        e.cyc  = cycle_cnt + LAT_8;
        e.name = "w8 s 80*7F";
        q_w8.push_back(e);
        applyStimulus("u 3*5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        start_ns  = 1'b0;
        start_8   = 1'b0;
        data_a_ns = 32'h5A5A_5A5A;
        data_a_8  = 8'h11;
        repeat (LAT) @(negedge clk);

        runOp("u FFFFFFFF^2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runOp("s -3*5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        runOp("s -3*-5", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'h0000_0000_0000_000F);
        runOp("s 80000000^2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        runOp("s 80000000*1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        runOp("s 7FFFFFFF*-1", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001);
        runOp("u 0*FFFFFFFF", 1'b0, 32'd0, 32'hFFFF_FFFF, 64'd0);

        // A second start mid-run must be ignored.
        applyStimulus("u 1234*10 midrun", 1'b0, 32'h1234, 32'h10, 64'h0000_0000_0001_2340);
        repeat (4) @(negedge clk);
        checkOutput("midrun busy", 64'(busy), 64'd1);
        checkOutput("midrun ready", 64'(ready), 64'd0);
        start     = 1'b1;
        is_signed = 1'b1;
        data_a    = 32'd9;
        data_b    = 32'hFFFF_FFF7;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 5) @(negedge clk);

        // Reset in RUN cycle 10 aborts: no done and a cleared result.
        applyStimulus("aborted 5*5", 1'b0, 32'd5, 32'd5, 64'd25);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        e = q_main.pop_back();
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort dataOut", data_out, 64'd0);
        checkOutput("abort ready", 64'(ready), 64'd1);
        checkOutput("abort busy", 64'(busy), 64'd0);
        repeat (LAT + 5) @(negedge clk);
        runOp("u 10000^2 after reset", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // Back-to-back: second request presented in the done cycle.
        applyStimulus("b2b 2*2", 1'b0, 32'd2, 32'd2, 64'd4);
        repeat (LAT - 1) @(negedge clk);
        checkOutput("done-cycle ready", 64'(ready), 64'd1);
        applyStimulus("b2b 7*6", 1'b0, 32'd7, 32'd6, 64'd42);
        repeat (LAT) @(negedge clk);

        // Bounded drain, then any missing completion counts as a failure.
        waited = 0;
        while ((q_main.size() + q_ns.size() + q_w8.size()) != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        while (q_main.size() != 0) begin
            e = q_main.pop_front();
            checks_total++;
            $display("[TB] FAIL %s missing done: got none, expected 0x%0h", e.name, e.data);
        end
        while (q_ns.size() != 0) begin
            e = q_ns.pop_front();
            checks_total++;
            $display("[TB] FAIL %s missing done: got none, expected 0x%0h", e.name, e.data);
        end
        while (q_w8.size() != 0) begin
            e = q_w8.pop_front();
            checks_total++;
            $display("[TB] FAIL %s missing done: got none, expected 0x%0h", e.name, e.data);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
